regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters (0=ALU, 1=load, 2=mul/div).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port req_valid  input  NREQ  requester i holds a write.
REQ-005 SHALL have port req_sel  input  NREQ x 5  destination register per requester.
REQ-006 SHALL have port req_dat  input  NREQ x word_t  write data per requester.
REQ-007 SHALL have port req_ready  output  NREQ  one-hot grant; transfer when valid and ready are both high.
REQ-008 SHALL have port rf_wen  output  1  register-file write enable.
REQ-009 SHALL have port rf_wsel  output  5  register-file write select.
REQ-010 SHALL have port rf_wdat  output  word_t  register-file write data.
REQ-011 SHALL have port iss_valid  input  1  instruction issued with a destination register.
REQ-012 SHALL have port iss_rd  input  5  destination of issued instruction.
REQ-013 SHALL have ports chk_rs1, chk_rs2  input  5 each  source registers to check.
REQ-014 SHALL have ports busy1, busy2  output  1 each  source has an uncommitted write.
REQ-015 SHALL have port err_spurious  output  1  sticky: write to a register not pending.

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready SHALL be combinational from req_valid and the priority pointer.
REQ-017 SHALL use round-robin priority: search starts at (last granted + 1) mod NREQ; pointer updates only on a transfer.
REQ-018 SHALL register the granted sel/dat into a single output stage; rf_wen SHALL assert exactly the cycle after the transfer (latency 1).
REQ-019 SHALL drain the output stage every cycle, so a grant is available every cycle with no stall.
REQ-020 SHALL hold rf_wen low when no transfer occurred in the previous cycle; rf_wsel/rf_wdat are don't-care then.
REQ-021 SHALL accept a transfer with req_sel=0 but SHALL drive rf_wen=0 for it.
REQ-022 SHALL keep a 31-bit pending scoreboard for x1..x31; x0 is never pending.
REQ-023 SHALL set pending[iss_rd] at the edge where iss_valid=1 and iss_rd!=0.
REQ-024 SHALL clear pending[rf_wsel] at the edge that ends the rf_wen cycle, so the negedge register-file write precedes the clear.
REQ-025 SHALL let set win over clear when both target the same register on the same edge.
REQ-026 SHALL drive busy1/busy2 combinationally as pending[chk_rs] (0 for x0) from the registered scoreboard, with no bypass.
REQ-027 SHALL set err_spurious when rf_wen=1 and pending[rf_wsel]=0; it stays set until reset.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, clear the scoreboard, rf_wen, rf_wsel, rf_wdat and err_spurious, and reset the pointer so requester 0 has priority next.
REQ-029 SHALL drive req_ready all-zero while rst=1; a request pending during reset is dropped and must be re-presented.

Structure
REQ-030 SHALL take word_t and a 5-bit regbits_t from common_types_pkg and add nothing to it.
REQ-031 SHALL implement the round-robin grant as sub-module rr_arbiter (parameter N; ports req, grant, advance, clk, rst).

Verification
REQ-032 Bench SHALL drive all three valid with sel 5/6/7 held, from reset -> grants 0,1,2,0 in consecutive cycles; rf_wen every cycle from cycle 2 with wsel 5,6,7.
REQ-033 Bench SHALL issue rd=10, then load write x10=0xDEADBEEF two cycles later -> busy1(rs1=10)=1 through the rf_wen cycle and 0 the cycle after; x10 reads 0xDEADBEEF.
REQ-034 Bench SHALL, in the rf_wen cycle for x10, issue iss_rd=10 again -> pending[10] stays 1 after the edge.
REQ-035 Bench SHALL have the ALU write x0=0x1234 -> transfer completes, rf_wen stays 0, busy for x0 stays 0, err_spurious stays 0.
REQ-036 Bench SHALL write x3 with no prior issue -> err_spurious=1 the cycle after rf_wen and stays 1; rst=1 for one cycle clears it.
REQ-037 Bench SHALL assert rst while requester 2 is valid and the pointer is at 1 -> req_ready=000 during reset; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared datapath types
package common_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - scoreboard types and lookup helper for the writeback arbiter
package regfile_wb_arbiter_pkg;
  import common_types_pkg::*;

  localparam int NUM_REGS = 32;

  typedef logic [NUM_REGS-1:0] pend_vec_t;

  // x0 is hardwired, so it can never report as busy
  function automatic logic pend_lookup(input pend_vec_t p, input regbits_t r);
    return (r != '0) && p[r];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant; the search starts just after the last winner
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] start_q;
  logic [PW-1:0] next_start;
  logic          found;
  int            sel_idx;

  always_comb begin
    found   = 1'b0;
    sel_idx = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && |(req & (N'(1) << ((int'(start_q) + k) % N)))) begin
        found   = 1'b1;
        sel_idx = (int'(start_q) + k) % N;
      end
    end
    // requests seen during reset are dropped, never granted
    grant      = (found && !rst) ? (N'(1) << sel_idx) : '0;
    next_start = PW'((sel_idx + 1) % N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
    end else if (advance) begin
      start_q <= next_start;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates writeback requesters onto one register-file write port
// and tracks which destinations still have an uncommitted write.
module regfile_wb_arbiter
  import common_types_pkg::*;
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  regbits_t [NREQ-1:0]  req_sel,
  input  word_t [NREQ-1:0]     req_dat,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_wen,
  output regbits_t             rf_wsel,
  output word_t                rf_wdat,
  input  logic                 iss_valid,
  input  regbits_t             iss_rd,
  input  regbits_t             chk_rs1,
  input  regbits_t             chk_rs2,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 err_spurious
);
  logic [NREQ-1:0] grant;
  logic            xfer;
  regbits_t        g_sel;
  word_t           g_dat;
  pend_vec_t       pending;
  pend_vec_t       pend_next;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .grant   (grant),
    .advance (xfer)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // grant is one-hot, so OR-merging the selected lanes is a clean mux
  always_comb begin
    g_sel = '0;
    g_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_sel = g_sel | req_sel[i];
        g_dat = g_dat | req_dat[i];
      end
    end
  end

  // clear first, then set, so a re-issue on the commit edge keeps the register pending
  always_comb begin
    pend_next = pending;
    if (rf_wen) begin
      pend_next[rf_wsel] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pend_next[iss_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen       <= 1'b0;
      rf_wsel      <= '0;
      rf_wdat      <= '0;
      pending      <= '0;
      err_spurious <= 1'b0;
    end else begin
      rf_wen <= xfer && (g_sel != '0);
      if (xfer) begin
        rf_wsel <= g_sel;
        rf_wdat <= g_dat;
      end
      pending      <= pend_next;
      err_spurious <= err_spurious | (rf_wen && !pending[rf_wsel]);
    end
  end

  assign busy1 = pend_lookup(pending, chk_rs1);
  assign busy2 = pend_lookup(pending, chk_rs2);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random checks of regfile_wb_arbiter against a reference model
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][4:0]   req_sel;
  logic [NREQ-1:0][31:0]  req_dat;
  logic [NREQ-1:0]        req_ready;
  logic                   rf_wen;
  logic [4:0]             rf_wsel;
  logic [31:0]            rf_wdat;
  logic                   iss_valid;
  logic [4:0]             iss_rd;
  logic [4:0]             chk_rs1;
  logic [4:0]             chk_rs2;
  logic                   busy1;
  logic                   busy2;
  logic                   err_spurious;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_dat      (req_dat),
    .req_ready    (req_ready),
    .rf_wen       (rf_wen),
    .rf_wsel      (rf_wsel),
    .rf_wdat      (rf_wdat),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .busy1        (busy1),
    .busy2        (busy2),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  // external register file, written on the falling edge of the rf_wen cycle
  logic [31:0] rf_mem [32];
  always @(negedge clk) begin
    if (rf_wen === 1'b1) rf_mem[rf_wsel] <= rf_wdat;
  end

  int checks = 0;
  int errors = 0;

  // reference model: next-priority index, pending set, one write in flight
  int          m_start;
  bit [31:0]   m_pend;
  bit          m_wen;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant_idx();
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_start + k) % NREQ;
      if (req_valid[idx[1:0]] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic logic model_busy(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_ready;
    #2;
    g = rst ? -1 : exp_grant_idx();
    exp_ready = (g < 0) ? '0 : NREQ'(1 << g);
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("busy1", 32'(busy1), 32'(model_busy(chk_rs1)));
    check_eq("busy2", 32'(busy2), 32'(model_busy(chk_rs2)));
    check_eq("rf_wen", 32'(rf_wen), 32'(m_wen));
    if (m_wen) begin
      check_eq("rf_wsel", 32'(rf_wsel), 32'(m_wsel));
      check_eq("rf_wdat", rf_wdat, m_wdat);
    end
    check_eq("err_spurious", 32'(err_spurious), 32'(m_err));
    @(posedge clk);
    if (rst) begin
      m_start = 0; m_pend = '0; m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_err = 1'b0;
    end else begin
      if (m_wen && !m_pend[m_wsel]) m_err = 1'b1;
      if (m_wen) m_pend[m_wsel] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
      if (g >= 0) begin
        m_wsel  = req_sel[g[1:0]];
        m_wdat  = req_dat[g[1:0]];
        m_wen   = (m_wsel != 5'd0);
        m_start = (g + 1) % NREQ;
      end else begin
        m_wen = 1'b0;
      end
    end
    #1;
  endtask

  logic [NREQ-1:0] rr_exp [4];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1; req_valid = '0; req_sel = '0; req_dat = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    m_start = 0; m_pend = '0; m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_err = 1'b0;
    @(posedge clk); #1;
    tick();

    // all three requesters held: grants rotate 0,1,2,0
    rst = 1'b0; req_valid = 3'b111;
    req_sel[0] = 5'd5; req_sel[1] = 5'd6; req_sel[2] = 5'd7;
    req_dat[0] = 32'h5555; req_dat[1] = 32'h6666; req_dat[2] = 32'h7777;
    for (int c = 0; c < 4; c++) begin
      #1 check_eq("rr_order", 32'(req_ready), 32'(rr_exp[c]));
      tick();
    end
    req_valid = '0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;

    // issue x10, load commits two cycles later
    chk_rs1 = 5'd10; chk_rs2 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd10; tick();
    iss_valid = 1'b0; tick();
    req_valid = 3'b010; req_sel[1] = 5'd10; req_dat[1] = 32'hDEADBEEF; tick();
    req_valid = '0;
    #1 check_eq("busy_in_wen_cycle", 32'(busy1), 32'd1);
    tick();
    check_eq("busy_after_commit", 32'(busy1), 32'd0);
    check_eq("x10_data", rf_mem[10], 32'hDEADBEEF);
    tick();

    // re-issue of x10 on the commit edge keeps it pending
    iss_valid = 1'b1; iss_rd = 5'd10; tick();
    iss_valid = 1'b0; tick();
    req_valid = 3'b010; req_dat[1] = 32'hCAFEF00D; tick();
    req_valid = '0; iss_valid = 1'b1; iss_rd = 5'd10; tick();
    iss_valid = 1'b0;
    #1 check_eq("set_wins_clear", 32'(busy1), 32'd1);
    tick();

    // write to x0: accepted but never reaches the register file
    chk_rs1 = 5'd0;
    req_valid = 3'b001; req_sel[0] = 5'd0; req_dat[0] = 32'h1234;
    #1 check_eq("x0_ready", 32'(req_ready), 32'(3'b001));
    tick();
    req_valid = '0;
    check_eq("x0_no_wen", 32'(rf_wen), 32'd0);
    tick();
    check_eq("x0_no_err", 32'(err_spurious), 32'd0);
    check_eq("x0_not_busy", 32'(busy1), 32'd0);
    tick();

    // write to x3 without an issue flags a spurious write
    req_valid = 3'b001; req_sel[0] = 5'd3; req_dat[0] = 32'h33; tick();
    req_valid = '0; tick();
    check_eq("spurious_set", 32'(err_spurious), 32'd1);
    tick(); tick();
    check_eq("spurious_sticky", 32'(err_spurious), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("spurious_cleared", 32'(err_spurious), 32'd0);

    // reset while requester 2 waits: request dropped, priority back to 0
    req_valid = 3'b010; tick();
    req_valid = 3'b100; rst = 1'b1;
    #1 check_eq("ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = 3'b111;
    #1 check_eq("first_after_reset", 32'(req_ready), 32'(3'b001));
    tick();
    req_valid = '0; tick();

    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      req_valid  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_sel[i] = 5'($urandom_range(0, 7));
        req_dat[i] = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; req_valid = '0; iss_valid = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
